cdc_wr_arbiter: RTL

- Shares the write port of one async_fifo (1-entry, edge-triggered push, registered wfull) among NUM_REQ requesters in the FIFO's write-clock domain.
- Arbitrates round-robin and tags each payload with the winner's index.
- Sequences the FIFO's push/full protocol so that no push reaches the FIFO while its registered wfull is stale. This prevents silent overwrite of the single entry.

---
 rtl/cdc_wr_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cdc_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdc_wr_arbiter
// Description : Shares the write port of a 1-entry async FIFO among NUM_REQ
//               requesters in the FIFO write-clock domain. Requesters are
//               arbitrated round-robin, and each payload is tagged with the
//               winner's index as {id, payload}. Push is sequenced as
//               PUSH -> ARM -> DRAIN so that no push reaches the FIFO while
//               its registered wfull may still be stale.
//               Optional build macro CDC_ARB_FIXED_PRIO_EN selects fixed
//               priority (lowest index wins) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_wr_arbiter #(
    parameter  int NUM_REQ   = 4,
    parameter  int DATA_W    = 48,
    parameter  int GUARD_CYC = 4,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      fifo_wpush,
    output logic [ID_W+DATA_W-1:0]    fifo_wdata,
    input  logic                      fifo_wfull,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      err_guard
);

    // Guard counter must be able to hold the value GUARD_CYC itself.
    localparam int GW = $clog2(GUARD_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PUSH  = 2'd1,
        ST_ARM   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                   state_q,  state_d;
    logic [ID_W-1:0]          ptr_q,    ptr_d;
    logic [GW-1:0]            guard_q,  guard_d;
    logic [ID_W+DATA_W-1:0]   wdata_q,  wdata_d;
    logic [ID_W-1:0]          grant_q,  grant_d;
    logic                     err_q,    err_d;
    logic                     wpush_q,  wpush_d;

    logic                     win_found;
    logic [ID_W-1:0]          win_idx;
    logic [DATA_W-1:0]        win_payload;
    logic [ID_W-1:0]          ptr_next;

    // Winner search: first valid index at/after the pointer with wrap-around,
    // or simply the lowest valid index when fixed priority is built in.
    always_comb begin
        int cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef CDC_ARB_FIXED_PRIO_EN
            cand = k;
`else
            cand = (int'(ptr_q) + k) % NUM_REQ;
`endif
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(cand);
            end
        end
    end

    // Payload of the current winner and the pointer value that follows it.
    always_comb begin
        win_payload = req_data[int'(win_idx)*DATA_W +: DATA_W];
`ifdef CDC_ARB_FIXED_PRIO_EN
        ptr_next    = '0;
`else
        ptr_next    = ID_W'((int'(win_idx) + 1) % NUM_REQ);
`endif
    end

    // Next-state and output decode for the push/full handshake sequence.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        guard_d   = guard_q;
        wdata_d   = wdata_q;
        grant_d   = grant_q;
        err_d     = err_q;
        req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                // Accept only when the FIFO entry is free; a cycle in which
                // reset is asserted never acknowledges a requester.
                if (!fifo_wfull && win_found && !rst) begin
                    req_ready[win_idx] = 1'b1;
                    wdata_d            = {win_idx, win_payload};
                    grant_d            = win_idx;
                    ptr_d              = ptr_next;
                    state_d            = ST_PUSH;
                end
            end
            ST_PUSH: begin
                state_d = ST_ARM;
                guard_d = '0;
            end
            ST_ARM: begin
                // wpush is low here, re-arming the FIFO's edge detector while
                // waiting for its registered full flag to catch up.
                if (fifo_wfull) begin
                    state_d = ST_DRAIN;
                end else begin
                    guard_d = guard_q + 1'b1;
                    if (guard_d == GW'(GUARD_CYC)) begin
                        err_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!fifo_wfull) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        wpush_d = (state_d == ST_PUSH);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            guard_q <= '0;
            wdata_q <= '0;
            grant_q <= '0;
            err_q   <= 1'b0;
            wpush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            guard_q <= guard_d;
            wdata_q <= wdata_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            wpush_q <= wpush_d;
        end
    end

    // Registered outputs; busy is a direct state decode.
    always_comb begin
        fifo_wpush = wpush_q;
        fifo_wdata = wdata_q;
        grant_id   = grant_q;
        err_guard  = err_q;
        busy       = (state_q != ST_IDLE);
    end

endmodule
`default_nettype wire
